// File: rtl/td4_core_param.sv
// Parametrised TD4 execute core: own fetch port, FETCH/EXEC state machine,
// valid/ready handshakes on IN/OUT, JC/HLT instructions and a halted state.
module td4_core_param #(
  parameter int DATA_W = 4,
  parameter int PC_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              exec_mode,
  output logic [PC_W-1:0]   imem_addr,
  input  logic [DATA_W+3:0] imem_data,
  input  logic [DATA_W-1:0] io_input,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] register_OUT,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] register_A,
  output logic [DATA_W-1:0] register_B,
  output logic [PC_W-1:0]   pc,
  output logic              register_carry,
  output logic              halted
);

  typedef enum logic [2:0] {FETCH, EXEC, WAIT_IN, WAIT_OUT, HALT} state_t;

  localparam logic [3:0] OP_ADD_A  = 4'b0000;
  localparam logic [3:0] OP_ADD_B  = 4'b1010;
  localparam logic [3:0] OP_MOV_AI = 4'b1100;
  localparam logic [3:0] OP_MOV_BI = 4'b1110;
  localparam logic [3:0] OP_MOV_AB = 4'b1000;
  localparam logic [3:0] OP_MOV_BA = 4'b0010;
  localparam logic [3:0] OP_JMP    = 4'b1111;
  localparam logic [3:0] OP_JNC    = 4'b0111;
  localparam logic [3:0] OP_JC     = 4'b0011;
  localparam logic [3:0] OP_IN_A   = 4'b0100;
  localparam logic [3:0] OP_IN_B   = 4'b0110;
  localparam logic [3:0] OP_OUT_B  = 4'b1001;
  localparam logic [3:0] OP_OUT_I  = 4'b1101;
  localparam logic [3:0] OP_HLT    = 4'b1011;

  state_t              state, state_n;
  logic [DATA_W+3:0]   ir, ir_n;
  logic [DATA_W-1:0]   a_n, b_n, out_n;
  logic [PC_W-1:0]     pc_n, pc_inc, jmp_tgt;
  logic                c_n, ov_n;
  logic [3:0]          opcode;
  logic [DATA_W-1:0]   imm;
  logic [DATA_W:0]     sum_a, sum_b;
  logic                is_in;

  assign opcode    = ir[DATA_W+3:DATA_W];
  assign imm       = ir[DATA_W-1:0];
  assign sum_a     = {1'b0, register_A} + {1'b0, imm};
  assign sum_b     = {1'b0, register_B} + {1'b0, imm};
  assign pc_inc    = pc + PC_W'(1);
  assign jmp_tgt   = imm[PC_W-1:0];
  assign is_in     = (opcode == OP_IN_A) || (opcode == OP_IN_B);
  assign in_ready  = ((state == EXEC) || (state == WAIT_IN)) && is_in;
  assign halted    = (state == HALT);
  assign imem_addr = pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= FETCH;
    else     state <= state_n;
  end

  // EXEC and both WAIT states share one decode: a WAIT state simply re-runs
  // the IN/OUT in IR until its handshake lets it complete.
  always_comb begin
    state_n = state;
    ir_n    = ir;
    a_n     = register_A;
    b_n     = register_B;
    out_n   = register_OUT;
    pc_n    = pc;
    c_n     = register_carry;
    ov_n    = out_valid;
    if (out_valid && out_ready) ov_n = 1'b0;
    unique case (state)
      FETCH: begin
        if (exec_mode) begin
          ir_n    = imem_data;
          state_n = EXEC;
        end
      end
      EXEC, WAIT_IN, WAIT_OUT: begin
        state_n = FETCH;
        pc_n    = pc_inc;
        c_n     = 1'b0;
        case (opcode)
          OP_ADD_A:  {c_n, a_n} = sum_a;
          OP_ADD_B:  {c_n, b_n} = sum_b;
          OP_MOV_AI: a_n = imm;
          OP_MOV_BI: b_n = imm;
          OP_MOV_AB: a_n = register_B;
          OP_MOV_BA: b_n = register_A;
          OP_JMP:    pc_n = jmp_tgt;
          OP_JNC:    if (!register_carry) pc_n = jmp_tgt;
          OP_JC:     if (register_carry) pc_n = jmp_tgt;
          OP_IN_A, OP_IN_B: begin
            if (in_valid) begin
              if (opcode == OP_IN_A) a_n = io_input;
              else                   b_n = io_input;
            end else begin
              state_n = WAIT_IN;
              pc_n    = pc;
              c_n     = register_carry;
            end
          end
          OP_OUT_B, OP_OUT_I: begin
            // A consume in the same cycle frees the slot for the new beat.
            if (!out_valid || out_ready) begin
              out_n = (opcode == OP_OUT_B) ? register_B : imm;
              ov_n  = 1'b1;
            end else begin
              state_n = WAIT_OUT;
              pc_n    = pc;
              c_n     = register_carry;
            end
          end
          OP_HLT:  state_n = HALT;
          default: ;
        endcase
      end
      HALT:    ;
      default: state_n = FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ir             <= '0;
      register_A     <= '0;
      register_B     <= '0;
      register_OUT   <= '0;
      pc             <= '0;
      register_carry <= 1'b0;
      out_valid      <= 1'b0;
    end else begin
      ir             <= ir_n;
      register_A     <= a_n;
      register_B     <= b_n;
      register_OUT   <= out_n;
      pc             <= pc_n;
      register_carry <= c_n;
      out_valid      <= ov_n;
    end
  end

endmodule

// File: tb/tb_td4_core_param.sv
// Bench for td4_core_param: directed scenarios on a 4/4 and an 8/6 instance,
// plus a random program on the 8/6 instance against an ISA-level model.
module tb_td4_core_param;

  logic clk = 1'b0, rst = 1'b1, exec_mode = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]  addr4, io4, a4, b4, o4, pc4;
  logic [7:0]  d4;
  logic        ir4, ov4, c4, h4;
  logic [7:0]  rom4 [16];
  assign d4 = rom4[addr4];

  logic [5:0]  addr8, pc8;
  logic [7:0]  io8, a8, b8, o8;
  logic [11:0] d8;
  logic        ir8, ov8, c8, h8;
  logic [11:0] rom8 [64];
  assign d8 = rom8[addr8];

  td4_core_param #(.DATA_W(4), .PC_W(4)) dut4 (
    .clk(clk), .rst(rst), .exec_mode(exec_mode), .imem_addr(addr4), .imem_data(d4),
    .io_input(io4), .in_valid(in_valid), .in_ready(ir4), .register_OUT(o4),
    .out_valid(ov4), .out_ready(out_ready), .register_A(a4), .register_B(b4),
    .pc(pc4), .register_carry(c4), .halted(h4));

  td4_core_param #(.DATA_W(8), .PC_W(6)) dut8 (
    .clk(clk), .rst(rst), .exec_mode(exec_mode), .imem_addr(addr8), .imem_data(d8),
    .io_input(io8), .in_valid(in_valid), .in_ready(ir8), .register_OUT(o8),
    .out_valid(ov8), .out_ready(out_ready), .register_A(a8), .register_B(b8),
    .pc(pc8), .register_carry(c8), .halted(h8));

  localparam logic [3:0] ADDA = 4'b0000, ADDB = 4'b1010, MOVAI = 4'b1100, MOVBI = 4'b1110;
  localparam logic [3:0] MOVAB = 4'b1000, MOVBA = 4'b0010, JMP = 4'b1111, JNC = 4'b0111;
  localparam logic [3:0] JC = 4'b0011, INA = 4'b0100, INB = 4'b0110, OUTB = 4'b1001;
  localparam logic [3:0] OUTI = 4'b1101, HLT = 4'b1011, NOP = 4'b0001;

  int errors = 0, checks = 0;

  task tick;
    @(posedge clk); #1;
  endtask

  task do_reset;
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
  endtask

  task clear_roms;
    for (int i = 0; i < 16; i++) rom4[i] = {NOP, 4'h0};
    for (int i = 0; i < 64; i++) rom8[i] = {NOP, 8'h00};
  endtask

  task test_reset;
    clear_roms();
    rom4[0] = {MOVAI, 4'd3};
    exec_mode = 1'b0;
    rst = 1'b1; #2;
    checks++;
    if ({a4, b4, pc4, o4, c4, ov4, ir4, h4, addr4} !== 23'd0) begin
      errors++; $display("FAIL reset4: got A=%0d B=%0d pc=%0d OUT=%0d c=%0d ov=%0d ir=%0d h=%0d want all 0",
                         a4, b4, pc4, o4, c4, ov4, ir4, h4);
    end
    checks++;
    if ({a8, b8, pc8, o8, c8, ov8, ir8, h8} !== 34'd0) begin
      errors++; $display("FAIL reset8: got A=%0h B=%0h pc=%0h OUT=%0h c=%0d ov=%0d want all 0", a8, b8, pc8, o8, c8, ov8);
    end
    @(posedge clk); #1; rst = 1'b0;
    repeat (4) tick();
    checks++;
    if ({a4, pc4} !== 8'h00) begin
      errors++; $display("FAIL no_exec_mode: got A=%0d pc=%0d want A=0 pc=0", a4, pc4);
    end
    exec_mode = 1'b1;
  endtask

  task test_add4;
    clear_roms();
    rom4[0] = {MOVAI, 4'd3}; rom4[1] = {ADDA, 4'd14}; rom4[2] = {MOVBI, 4'd0};
    do_reset();
    repeat (4) tick();
    checks++;
    if ({c4, a4, pc4} !== {1'b1, 4'd1, 4'd2}) begin
      errors++; $display("FAIL add4: got c=%0d A=%0d pc=%0d want c=1 A=1 pc=2", c4, a4, pc4);
    end
    repeat (2) tick();
    checks++;
    if ({c4, b4, pc4} !== {1'b0, 4'd0, 4'd3}) begin
      errors++; $display("FAIL mov_clears_carry: got c=%0d B=%0d pc=%0d want c=0 B=0 pc=3", c4, b4, pc4);
    end
  endtask

  task test_add8_jc;
    clear_roms();
    rom8[0] = {MOVAI, 8'h01}; rom8[1] = {ADDA, 8'hFF}; rom8[2] = {JC, 8'h2A};
    do_reset();
    repeat (4) tick();
    checks++;
    if ({c8, a8} !== {1'b1, 8'h00}) begin
      errors++; $display("FAIL add8: got c=%0d A=%0h want c=1 A=0", c8, a8);
    end
    repeat (2) tick();
    checks++;
    if ({c8, pc8} !== {1'b0, 6'h2A}) begin
      errors++; $display("FAIL jc8: got c=%0d pc=%0h want c=0 pc=2a", c8, pc8);
    end
  endtask

  task test_in_wait;
    clear_roms();
    rom4[0] = {INA, 4'd0};
    in_valid = 1'b0; io4 = 4'd0;
    do_reset();
    tick();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({ir4, a4, pc4} !== {1'b1, 4'd0, 4'd0}) begin
        errors++; $display("FAIL in_wait%0d: got ready=%0d A=%0d pc=%0d want ready=1 A=0 pc=0", i, ir4, a4, pc4);
      end
      tick();
    end
    in_valid = 1'b1; io4 = 4'd9;
    checks++;
    if (ir4 !== 1'b1) begin
      errors++; $display("FAIL in_ready_last: got %0d want 1", ir4);
    end
    tick();
    in_valid = 1'b0;
    checks++;
    if ({ir4, a4, pc4} !== {1'b0, 4'd9, 4'd1}) begin
      errors++; $display("FAIL in_xfer: got ready=%0d A=%0d pc=%0d want ready=0 A=9 pc=1", ir4, a4, pc4);
    end
    repeat (2) tick();
    checks++;
    if ({a4, pc4} !== {4'd9, 4'd2}) begin
      errors++; $display("FAIL in_once: got A=%0d pc=%0d want A=9 pc=2", a4, pc4);
    end
  endtask

  task test_back_to_back_out;
    clear_roms();
    rom4[0] = {OUTI, 4'd5}; rom4[1] = {OUTI, 4'd6};
    out_ready = 1'b0;
    do_reset();
    repeat (6) tick();
    checks++;
    if ({ov4, o4, pc4} !== {1'b1, 4'd5, 4'd1}) begin
      errors++; $display("FAIL out_stall: got ov=%0d OUT=%0d pc=%0d want ov=1 OUT=5 pc=1", ov4, o4, pc4);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if ({ov4, o4, pc4} !== {1'b1, 4'd6, 4'd2}) begin
      errors++; $display("FAIL out_swap: got ov=%0d OUT=%0d pc=%0d want ov=1 OUT=6 pc=2", ov4, o4, pc4);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if ({ov4, o4} !== {1'b0, 4'd6}) begin
      errors++; $display("FAIL out_consume: got ov=%0d OUT=%0d want ov=0 OUT=6", ov4, o4);
    end
  endtask

  task test_wrap_halt;
    clear_roms();
    rom4[0] = {JMP, 4'd15}; rom4[15] = {NOP, 4'd0};
    do_reset();
    repeat (2) tick();
    checks++;
    if (pc4 !== 4'd15) begin
      errors++; $display("FAIL jmp15: got pc=%0d want 15", pc4);
    end
    repeat (2) tick();
    checks++;
    if (pc4 !== 4'd0) begin
      errors++; $display("FAIL pc_wrap: got pc=%0d want 0", pc4);
    end
    rom4[0] = {MOVAI, 4'd6}; rom4[1] = {HLT, 4'd0};
    repeat (4) tick();
    for (int i = 0; i < 20; i++) begin
      checks++;
      if ({h4, a4, b4, pc4, c4} !== {1'b1, 4'd6, 4'd0, 4'd2, 1'b0}) begin
        errors++; $display("FAIL halt%0d: got h=%0d A=%0d B=%0d pc=%0d c=%0d want h=1 A=6 B=0 pc=2 c=0",
                           i, h4, a4, b4, pc4, c4);
      end
      tick();
    end
    rst = 1'b1; #1;
    checks++;
    if ({h4, a4, b4, pc4, c4, ov4, ir4, o4} !== 19'd0) begin
      errors++; $display("FAIL halt_reset: got h=%0d A=%0d pc=%0d want all 0", h4, a4, pc4);
    end
    @(posedge clk); #1; rst = 1'b0;
    repeat (2) tick();
    checks++;
    if ({h4, a4, pc4} !== {1'b0, 4'd6, 4'd1}) begin
      errors++; $display("FAIL post_halt_run: got h=%0d A=%0d pc=%0d want h=0 A=6 pc=1", h4, a4, pc4);
    end
  endtask

  task test_async_reset;
    clear_roms();
    rom4[0] = {MOVAI, 4'd5}; rom4[1] = {INB, 4'd0};
    in_valid = 1'b0;
    do_reset();
    repeat (4) tick();
    checks++;
    if ({ir4, a4, pc4} !== {1'b1, 4'd5, 4'd1}) begin
      errors++; $display("FAIL wait_in_setup: got ready=%0d A=%0d pc=%0d want ready=1 A=5 pc=1", ir4, a4, pc4);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({ir4, a4, pc4, b4} !== 13'd0) begin
      errors++; $display("FAIL async_reset: got ready=%0d A=%0d pc=%0d B=%0d want all 0", ir4, a4, pc4, b4);
    end
    #1 rst = 1'b0;
  endtask

  task test_random;
    logic [7:0] ma, mb, mo, im;
    logic [5:0] mpc;
    logic       mc, mv;
    logic [3:0] op;
    logic [8:0] s;
    for (int i = 0; i < 64; i++) begin
      op = 4'($urandom_range(0, 15));
      if (op == HLT) op = NOP;
      rom8[i] = {op, 8'($urandom)};
    end
    io8 = 8'($urandom);
    in_valid = 1'b1; out_ready = 1'b1;
    do_reset();
    ma = '0; mb = '0; mo = '0; mpc = '0; mc = 1'b0;
    for (int n = 0; n < 150; n++) begin
      {op, im} = rom8[mpc];
      mv = 1'b0;
      case (op)
        ADDA:  begin s = {1'b0, ma} + {1'b0, im}; ma = s[7:0]; end
        ADDB:  begin s = {1'b0, mb} + {1'b0, im}; mb = s[7:0]; end
        MOVAI: ma = im;
        MOVBI: mb = im;
        MOVAB: ma = mb;
        MOVBA: mb = ma;
        INA:   ma = io8;
        INB:   mb = io8;
        OUTB:  begin mo = mb; mv = 1'b1; end
        OUTI:  begin mo = im; mv = 1'b1; end
        default: ;
      endcase
      if (op == JMP || (op == JNC && !mc) || (op == JC && mc)) mpc = im[5:0];
      else mpc = mpc + 6'd1;
      mc = (op == ADDA || op == ADDB) ? s[8] : 1'b0;
      repeat (2) tick();
      checks++;
      if ({a8, b8, pc8, c8, o8, ov8} !== {ma, mb, mpc, mc, mo, mv}) begin
        errors++; $display("FAIL rand%0d op=%b: got A=%0h B=%0h pc=%0h c=%0d OUT=%0h ov=%0d want A=%0h B=%0h pc=%0h c=%0d OUT=%0h ov=%0d",
                           n, op, a8, b8, pc8, c8, o8, ov8, ma, mb, mpc, mc, mo, mv);
      end
    end
    in_valid = 1'b0; out_ready = 1'b0;
  endtask

  initial begin
    io4 = 4'd0; io8 = 8'd0;
    test_reset();
    test_add4();
    test_add8_jc();
    test_in_wait();
    test_back_to_back_out();
    test_wrap_halt();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
